// File: rtl/xnor_correlator_pkg.sv
// Shared definitions for the XNOR bit-stream correlator: FSM state encoding
// and the helper that sizes the score/threshold fields from the window width.
package xnor_correlator_pkg;

  // Correlator operating modes
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    TRACK = 2'd2
  } state_e;

  localparam int DEFAULT_N = 8;

  // Bits needed to hold an agreeing-bit count from 0 up to and including n
  function automatic int sw_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/xnor_correlator_popcount.sv
// Combinational XNOR bank followed by a population count: returns how many
// window bits agree with the reference pattern.
module xnor_popcount #(
  parameter int N  = 8,
  parameter int SW = 4
) (
  input  logic [N-1:0]  window,
  input  logic [N-1:0]  pattern,
  output logic [SW-1:0] count
);

  logic [N-1:0] sim;

  // Bitwise agreement, then sum of the agreeing bits
  always_comb begin
    sim   = ~(window ^ pattern);
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + SW'(sim[i]);
    end
  end

endmodule

// File: rtl/xnor_correlator.sv
// Serial sync-word detector. Incoming bits shift into an N-bit window; once
// the window is full every accepted bit is scored against the loaded pattern
// and a match pulse is raised when enough bits agree. Score, valid and match
// are registered one edge after the window update.
module xnor_correlator
  import xnor_correlator_pkg::*;
#(
  parameter  int N   = DEFAULT_N,
  parameter  int HCW = 16,
  localparam int SW  = sw_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           din_valid,
  input  logic           din,
  input  logic           pat_load,
  input  logic [N-1:0]   pat_in,
  input  logic [SW-1:0]  thresh,
  output logic [SW-1:0]  score,
  output logic           score_valid,
  output logic           match,
  output logic           locked,
  output logic [HCW-1:0] hit_count
);

  localparam logic [HCW-1:0] HIT_MAX  = '1;
  localparam logic [SW-1:0]  FILL_END = SW'(N - 1);

  state_e         state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic [N-1:0]   pat_q, pat_d;
  logic [SW-1:0]  thresh_q, thresh_d;
  logic [SW-1:0]  fill_cnt_q, fill_cnt_d;
  logic           eval_q, eval_d;
  logic [SW-1:0]  score_q, score_d;
  logic           score_valid_q, score_valid_d;
  logic           match_q, match_d;
  logic [HCW-1:0] hit_count_q, hit_count_d;
  logic           shift_en;
  logic [SW-1:0]  window_score;

  // Score of the window currently held in the shift register
  xnor_popcount #(
    .N  (N),
    .SW (SW)
  ) u_popcount (
    .window  (sr_q),
    .pattern (pat_q),
    .count   (window_score)
  );

  // Mode sequencing: a load always restarts filling and discards any bit
  // arriving on the same edge; the N-th fill bit enters TRACK and is scored
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    eval_d     = 1'b0;
    shift_en   = 1'b0;
    if (pat_load) begin
      state_d    = FILL;
      fill_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        FILL: begin
          if (din_valid) begin
            shift_en = 1'b1;
            if (fill_cnt_q == FILL_END) begin
              state_d    = TRACK;
              fill_cnt_d = '0;
              eval_d     = 1'b1;
            end else begin
              fill_cnt_d = fill_cnt_q + 1'b1;
            end
          end
        end
        TRACK: begin
          if (din_valid) begin
            shift_en = 1'b1;
            eval_d   = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Window, reference capture and output pulses. A pulse in flight when a
  // load arrives still emits against the old pattern, but the hit counter
  // clear takes priority over that pulse's increment.
  always_comb begin
    sr_d          = sr_q;
    pat_d         = pat_q;
    thresh_d      = thresh_q;
    score_valid_d = eval_q;
    match_d       = eval_q && (window_score >= thresh_q);
    score_d       = eval_q ? window_score : score_q;
    hit_count_d   = hit_count_q;
    if (pat_load) begin
      pat_d    = pat_in;
      thresh_d = thresh;
      sr_d     = '0;
    end else if (shift_en) begin
      sr_d = {sr_q[N-2:0], din};
    end
    if (pat_load) begin
      hit_count_d = '0;
    end else if (match_d && (hit_count_q != HIT_MAX)) begin
      hit_count_d = hit_count_q + 1'b1;
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      pat_q         <= '0;
      thresh_q      <= '0;
      fill_cnt_q    <= '0;
      eval_q        <= 1'b0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      match_q       <= 1'b0;
      hit_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      pat_q         <= pat_d;
      thresh_q      <= thresh_d;
      fill_cnt_q    <= fill_cnt_d;
      eval_q        <= eval_d;
      score_q       <= score_d;
      score_valid_q <= score_valid_d;
      match_q       <= match_d;
      hit_count_q   <= hit_count_d;
    end
  end

  assign score       = score_q;
  assign score_valid = score_valid_q;
  assign match       = match_q;
  assign locked      = (state_q == TRACK);
  assign hit_count   = hit_count_q;

endmodule

// File: tb/tb_xnor_correlator.sv
// Bench for xnor_correlator: two instances (16-bit and 4-bit hit counters)
// share one stimulus stream; a queue-based model predicts every output.
module tb_xnor_correlator;
  import xnor_correlator_pkg::*;

  localparam int N  = 8;
  localparam int SW = sw_width(N);

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          din_valid = 1'b0;
  logic          din       = 1'b0;
  logic          pat_load  = 1'b0;
  logic [N-1:0]  pat_in    = '0;
  logic [SW-1:0] thresh    = '0;

  logic [SW-1:0] score_a, score_b;
  logic          valid_a, valid_b, match_a, match_b, locked_a, locked_b;
  logic [15:0]   hit_a;
  logic [3:0]    hit_b;

  int vectors    = 0;
  int miscompares = 0;

  xnor_correlator #(.N(N), .HCW(16)) dut_a (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pat_in(pat_in), .thresh(thresh), .score(score_a), .score_valid(valid_a),
    .match(match_a), .locked(locked_a), .hit_count(hit_a)
  );

  xnor_correlator #(.N(N), .HCW(4)) dut_b (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pat_in(pat_in), .thresh(thresh), .score(score_b), .score_valid(valid_b),
    .match(match_b), .locked(locked_b), .hit_count(hit_b)
  );

  always #5 clk = ~clk;

  // Model: history of accepted bits since the last load; a full history
  // means a window is scored and reported one edge later.
  bit           hist[$];
  bit           loaded = 0;
  logic [N-1:0] m_pat = '0;
  int           m_thresh = 0;
  bit           pend = 0;
  int           pend_score = 0;
  bit           pend_match = 0;
  int           exp_score = 0, exp_valid = 0, exp_match = 0, exp_locked = 0;
  int           exp_hit16 = 0, exp_hit4 = 0;

  function automatic int agree();
    int cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (hist[hist.size() - 1 - i] == m_pat[i]) cnt++;
    end
    return cnt;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        hist.delete();
        loaded = 0; m_pat = '0; m_thresh = 0; pend = 0;
        exp_score = 0; exp_valid = 0; exp_match = 0; exp_locked = 0;
        exp_hit16 = 0; exp_hit4 = 0;
      end else begin
        exp_valid = pend ? 1 : 0;
        exp_match = (pend && pend_match) ? 1 : 0;
        if (pend) exp_score = pend_score;
        if (pat_load) begin
          exp_hit16 = 0;
          exp_hit4  = 0;
        end else if (exp_match == 1) begin
          if (exp_hit16 < 65535) exp_hit16++;
          if (exp_hit4 < 15) exp_hit4++;
        end
        pend = 0;
        if (pat_load) begin
          loaded = 1;
          m_pat = pat_in;
          m_thresh = int'(thresh);
          hist.delete();
        end else if (loaded && din_valid) begin
          hist.push_back(din);
          if (hist.size() > N) void'(hist.pop_front());
          if (hist.size() == N) begin
            pend = 1;
            pend_score = agree();
            pend_match = (pend_score >= m_thresh);
          end
        end
        exp_locked = (loaded && hist.size() == N) ? 1 : 0;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, away from the rising edge, both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("score_a",  int'(score_a),  exp_score);
      checkOutput("valid_a",  int'(valid_a),  exp_valid);
      checkOutput("match_a",  int'(match_a),  exp_match);
      checkOutput("locked_a", int'(locked_a), exp_locked);
      checkOutput("hit_a",    int'(hit_a),    exp_hit16);
      checkOutput("score_b",  int'(score_b),  exp_score);
      checkOutput("valid_b",  int'(valid_b),  exp_valid);
      checkOutput("match_b",  int'(match_b),  exp_match);
      checkOutput("locked_b", int'(locked_b), exp_locked);
      checkOutput("hit_b",    int'(hit_b),    exp_hit4);
    end
  end

  // Drive one cycle of inputs, let a rising edge consume them, return 2 units later
  task automatic applyStimulus(input logic v, input logic d, input logic pl,
                               input logic [N-1:0] p, input logic [SW-1:0] th);
    din_valid = v;
    din       = d;
    pat_load  = pl;
    pat_in    = p;
    thresh    = th;
    @(posedge clk);
    #2;
  endtask

  task automatic loadPattern(input logic [N-1:0] p, input logic [SW-1:0] th);
    applyStimulus(1'b0, 1'b0, 1'b1, p, th);
  endtask

  // Pattern/threshold inputs are scrambled on purpose: they must be ignored
  task automatic sendBit(input logic b);
    applyStimulus(1'b1, b, 1'b0, N'($urandom), SW'($urandom));
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, N'($urandom), SW'($urandom));
  endtask

  task automatic sendPattern(input logic [N-1:0] p);
    for (int i = N - 1; i >= 0; i--) sendBit(p[i]);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] pa5 = 8'hA5;
    logic [N-1:0] p5a = 8'h5A;

    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_score", int'(score_a), 0);
    checkOutput("rst_locked", int'(locked_a), 0);
    checkOutput("rst_hit", int'(hit_a), 0);
    rst = 1'b0;
    idle();

    // Exact pattern match, then one more bit giving window 4B
    loadPattern(pa5, 4'd8);
    sendPattern(pa5);
    checkOutput("t1_locked_early", int'(locked_a), 1);
    checkOutput("t1_valid_early", int'(valid_a), 0);
    sendBit(1'b1);
    checkOutput("t1_score", int'(score_a), 8);
    checkOutput("t1_match", int'(match_a), 1);
    checkOutput("t1_hit", int'(hit_a), 1);
    idle();
    checkOutput("t2_score", int'(score_a), 2);
    checkOutput("t2_match", int'(match_a), 0);
    checkOutput("t2_hit", int'(hit_a), 1);

    // Threshold zero matches anything; threshold above N never matches
    loadPattern(8'h3C, 4'd0);
    for (int i = 0; i < N; i++) sendBit(1'($urandom));
    idle();
    checkOutput("t3_valid", int'(valid_a), 1);
    checkOutput("t3_match", int'(match_a), 1);
    loadPattern(p5a, 4'd9);
    sendPattern(p5a);
    idle();
    checkOutput("t3_score9", int'(score_a), 8);
    checkOutput("t3_match9", int'(match_a), 0);

    // Load colliding with a data bit during TRACK; window B5 in flight
    sendBit(1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, p5a, 4'd8);
    checkOutput("t4_inflight_valid", int'(valid_a), 1);
    checkOutput("t4_inflight_score", int'(score_a), 1);
    checkOutput("t4_locked_drop", int'(locked_a), 0);
    for (int i = N - 1; i >= 1; i--) sendBit(p5a[i]);
    checkOutput("t4_locked_7", int'(locked_a), 0);
    sendBit(p5a[0]);
    checkOutput("t4_locked_8", int'(locked_a), 1);
    checkOutput("t4_valid_8", int'(valid_a), 0);
    idle();
    checkOutput("t4_score", int'(score_a), 8);
    checkOutput("t4_hit", int'(hit_a), 1);

    // Saturation of the 4-bit counter: 23 matching windows
    loadPattern(8'hFF, 4'd8);
    for (int i = 0; i < 30; i++) sendBit(1'b1);
    idle();
    checkOutput("t5_hit4", int'(hit_b), 15);
    checkOutput("t5_hit16", int'(hit_a), 23);

    // Reset in the middle of filling
    loadPattern(pa5, 4'd8);
    for (int i = 0; i < 5; i++) sendBit(1'b1);
    rst = 1'b1;
    #1;
    checkOutput("t6_score", int'(score_a), 0);
    checkOutput("t6_hit", int'(hit_a), 0);
    checkOutput("t6_locked", int'(locked_a), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) sendBit(1'b1);
    idle();
    checkOutput("t6_idle_valid", int'(valid_a), 0);
    checkOutput("t6_idle_locked", int'(locked_a), 0);
    loadPattern(pa5, 4'd8);
    sendPattern(pa5);
    idle();
    checkOutput("t6_recover_match", int'(match_a), 1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
